// File: rtl/mul_arbiter_pkg.sv
// Shared types and constants for the multiplier arbiter.
// Optional feature: MUL_ARBITER_ZERO_BYPASS_EN (uses is_zero_op below).
package mul_arbiter_pkg;

   typedef enum logic [1:0] {
      MArbIdle    = 2'd0,
      MArbBusy    = 2'd1,
      MArbRelease = 2'd2
   } marb_state_e;

   localparam logic        MulStart = 1'b1;
   localparam logic        MulStop  = 1'b0;
   localparam logic [31:0] ZeroWord = 32'h0000_0000;

   // Either operand zero means the product is trivially zero.
   function automatic logic is_zero_op(input logic [31:0] a, input logic [31:0] b);
      return (a == ZeroWord) || (b == ZeroWord);
   endfunction

endpackage

// File: rtl/mul_arbiter_if.sv
// Requester and multiplier bus of the multiplier arbiter.
// Suffixes are from the arbiter's point of view: slave = arbiter, master = environment.
interface mul_arbiter_if;

   logic [1:0]  req_valid_i;
   logic [1:0]  req_signed_i;
   logic [63:0] req_a_i;
   logic [63:0] req_b_i;
   logic [1:0]  req_cancel_i;
   logic [1:0]  req_accept_o;
   logic [1:0]  resp_valid_o;
   logic [63:0] resp_result_o;
   logic        mul_start_o;
   logic        mul_signed_o;
   logic [31:0] mul_ina_o;
   logic [31:0] mul_inb_o;
   logic [63:0] mul_result_i;
   logic        mul_ready_i;

   modport slave (
      input  req_valid_i, req_signed_i, req_a_i, req_b_i, req_cancel_i,
      input  mul_result_i, mul_ready_i,
      output req_accept_o, resp_valid_o, resp_result_o,
      output mul_start_o, mul_signed_o, mul_ina_o, mul_inb_o
   );

   modport master (
      output req_valid_i, req_signed_i, req_a_i, req_b_i, req_cancel_i,
      output mul_result_i, mul_ready_i,
      input  req_accept_o, resp_valid_o, resp_result_o,
      input  mul_start_o, mul_signed_o, mul_ina_o, mul_inb_o
   );

endinterface

// File: rtl/mul_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: masked requests, pointer moves only on a taken grant.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] i_req,
   input  logic [1:0] i_mask,
   input  logic       i_update,
   output logic [1:0] o_gnt
);

   logic       r_prio;  // 0: requester 0 wins a tie, 1: requester 1 wins a tie
   logic [1:0] w_req;

   // One-hot grant among unmasked requests; tie broken by the pointer.
   always_comb begin
      w_req = i_req & ~i_mask;
      o_gnt = 2'b00;
      if (w_req == 2'b11) begin
         o_gnt = r_prio ? 2'b10 : 2'b01;
      end else begin
         o_gnt = w_req;
      end
   end

   // Hand priority to the requester that did not just win.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_prio <= 1'b0;
      end else if (i_update && (o_gnt != 2'b00)) begin
         r_prio <= o_gnt[0];
      end
   end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one iterative 32x32 multiplier between two requesters with round-robin grant,
// operand latching, start/ready handshake (with a forced start-low release cycle),
// per-requester cancel and a sticky BUSY watchdog.
// Optional feature: MUL_ARBITER_ZERO_BYPASS_EN returns zero products without the multiplier.
module mul_arbiter
   import mul_arbiter_pkg::*;
#(
   parameter int unsigned WATCHDOG_CYCLES = 64
) (
   input  logic         clk,
   input  logic         rst,
   mul_arbiter_if.slave bus,
   output logic         busy_o,
   output logic         timeout_o
);

   localparam int unsigned WdW = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
   localparam logic [WdW-1:0] WdLast = WdW'(WATCHDOG_CYCLES - 1);

   marb_state_e  r_state;
   marb_state_e  w_state_nxt;

   logic         w_grant_en;
   logic [1:0]   w_arb_req;
   logic [1:0]   w_gnt;
   logic         w_gnt_idx;
   logic [31:0]  w_sel_a;
   logic [31:0]  w_sel_b;
   logic         w_sel_signed;
   logic         w_bypass;
   logic         w_cancel_now;

   logic         r_owner;
   logic         r_cancel;
   logic         r_mul_start;
   logic         r_mul_signed;
   logic [31:0]  r_ina;
   logic [31:0]  r_inb;
   logic [1:0]   r_resp_valid;
   logic [63:0]  r_resp_result;
   logic [WdW-1:0] r_wd_cnt;
   logic         r_timeout;

   // Grants only from IDLE once the multiplier has dropped ready; held off during reset.
   assign w_grant_en   = (r_state == MArbIdle) && !bus.mul_ready_i && rst;
   assign w_arb_req    = bus.req_valid_i & {2{w_grant_en}};
   assign w_gnt_idx    = w_gnt[1];
   assign w_sel_a      = w_gnt_idx ? bus.req_a_i[63:32] : bus.req_a_i[31:0];
   assign w_sel_b      = w_gnt_idx ? bus.req_b_i[63:32] : bus.req_b_i[31:0];
   assign w_sel_signed = w_gnt_idx ? bus.req_signed_i[1] : bus.req_signed_i[0];
   assign w_cancel_now = r_cancel | bus.req_cancel_i[r_owner];

`ifdef MUL_ARBITER_ZERO_BYPASS_EN
   assign w_bypass = is_zero_op(w_sel_a, w_sel_b);
`else
   assign w_bypass = 1'b0;
`endif

   rr_arb2 u_rr_arb2 (
      .clk      (clk),
      .rst      (rst),
      .i_req    (w_arb_req),
      .i_mask   (bus.req_cancel_i),
      .i_update (w_grant_en),
      .o_gnt    (w_gnt)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= MArbIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state: IDLE -> BUSY on a real grant, BUSY -> RELEASE on ready, RELEASE -> IDLE on !ready.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         MArbIdle: begin
            if ((w_gnt != 2'b00) && !w_bypass) begin
               w_state_nxt = MArbBusy;
            end
         end
         MArbBusy: begin
            if (bus.mul_ready_i) begin
               w_state_nxt = MArbRelease;
            end
         end
         MArbRelease: begin
            if (!bus.mul_ready_i) begin
               w_state_nxt = MArbIdle;
            end
         end
         default: w_state_nxt = MArbIdle;
      endcase
   end

   // Datapath: operand latch, start handshake, response capture, cancel flag and watchdog.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_owner       <= 1'b0;
         r_cancel      <= 1'b0;
         r_mul_start   <= MulStop;
         r_mul_signed  <= 1'b0;
         r_ina         <= ZeroWord;
         r_inb         <= ZeroWord;
         r_resp_valid  <= 2'b00;
         r_resp_result <= 64'h0;
         r_wd_cnt      <= '0;
         r_timeout     <= 1'b0;
      end else begin
         r_resp_valid <= 2'b00;
         unique case (r_state)
            MArbIdle: begin
               if (w_gnt != 2'b00) begin
                  r_owner      <= w_gnt_idx;
                  r_cancel     <= 1'b0;
                  r_mul_signed <= w_sel_signed;
                  r_ina        <= w_sel_a;
                  r_inb        <= w_sel_b;
                  r_wd_cnt     <= '0;
                  if (w_bypass) begin
                     r_resp_valid  <= w_gnt;
                     r_resp_result <= 64'h0;
                  end else begin
                     r_mul_start <= MulStart;
                  end
               end
            end
            MArbBusy: begin
               if (bus.req_cancel_i[r_owner]) begin
                  r_cancel <= 1'b1;
               end
               // Counter parks at its last value; the flag stays set until reset.
               if (r_wd_cnt == WdLast) begin
                  r_timeout <= 1'b1;
               end else begin
                  r_wd_cnt <= r_wd_cnt + 1'b1;
               end
               if (bus.mul_ready_i) begin
                  r_mul_start <= MulStop;
                  if (!w_cancel_now) begin
                     r_resp_valid[r_owner] <= 1'b1;
                     r_resp_result         <= bus.mul_result_i;
                  end
               end
            end
            default: begin
               r_mul_start <= MulStop;
            end
         endcase
      end
   end

   // Outputs: accept is the live grant, everything else comes straight from registers.
   always_comb begin
      bus.req_accept_o  = w_gnt;
      bus.resp_valid_o  = r_resp_valid;
      bus.resp_result_o = r_resp_result;
      bus.mul_start_o   = r_mul_start;
      bus.mul_signed_o  = r_mul_signed;
      bus.mul_ina_o     = r_ina;
      bus.mul_inb_o     = r_inb;
      busy_o            = (r_state != MArbIdle);
      timeout_o         = r_timeout;
   end

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter with a behavioural iterative-multiplier model.
module tb_mul_arbiter;

   localparam int MulLat = 35;
   localparam int StdLat = 37;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic busy;
   logic timeout;
   logic never_ready = 1'b0;
   logic last_g = 1'b1;             // model: last granted requester (1 -> requester 0 favoured)
   logic [63:0] last_result = 64'h0;
   int cyc = 0;
   int total = 0;
   int bad = 0;
   int m_cnt = 0;
   int start_cycles = 0;

   mul_arbiter_if bus ();

   mul_arbiter #(
      .WATCHDOG_CYCLES (64)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .busy_o    (busy),
      .timeout_o (timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) if (bus.mul_start_o) start_cycles <= start_cycles + 1;

   function automatic logic [63:0] prod(input logic s, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      if (s) return sa * sb;
      return {32'h0, a} * {32'h0, b};
   endfunction

   function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_ARBITER_ZERO_BYPASS_EN
      if (a == 32'h0 || b == 32'h0) return 1;
`endif
      return StdLat;
   endfunction

   function automatic logic [31:0] pick_op();
      logic [31:0] tbl [4];
      tbl[0] = 32'h0000_0001;
      tbl[1] = 32'h7FFF_FFFF;
      tbl[2] = 32'h8000_0000;
      tbl[3] = 32'hFFFF_FFFF;
      if ($urandom_range(0, 3) == 0) return tbl[$urandom_range(0, 3)];
      return $urandom() | 32'h1;
   endfunction

   // Multiplier model: ready after MulLat cycles of start, drops when start drops.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.mul_ready_i  <= 1'b0;
         bus.mul_result_i <= 64'h0;
         m_cnt            <= 0;
      end else if (!bus.mul_start_o) begin
         bus.mul_ready_i <= 1'b0;
         m_cnt           <= 0;
      end else if (!bus.mul_ready_i && !never_ready) begin
         if (m_cnt == MulLat - 1) begin
            bus.mul_ready_i  <= 1'b1;
            bus.mul_result_i <= prod(bus.mul_signed_o, bus.mul_ina_o, bus.mul_inb_o);
         end else begin
            m_cnt <= m_cnt + 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic await_accept(input logic [1:0] exp_gnt, output logic ok, output int t_acc);
      int n = 0;
      @(negedge clk);
      while (bus.req_accept_o == 2'b00 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("accept", 64'(bus.req_accept_o), 64'(exp_gnt));
      ok    = (bus.req_accept_o != 2'b00);
      t_acc = cyc;
   endtask

   task automatic await_resp(input int g, input logic [63:0] exp_res, input int lat,
                             input int t_acc);
      int n = 0;
      logic [1:0] exp_v;
      exp_v = 2'b01 << g;
      @(negedge clk);
      while (bus.resp_valid_o == 2'b00 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("resp_valid", 64'(bus.resp_valid_o), 64'(exp_v));
      chk("result", bus.resp_result_o, exp_res);
      chk("latency", 64'(cyc - t_acc), 64'(lat));
      chk("start_low_at_resp", 64'(bus.mul_start_o), 64'h0);
      last_result = exp_res;
   endtask

   // Present the pending requesters and serve them all, checking order and products.
   task automatic serve(input logic [1:0] pend_in, input logic [1:0] sgn,
                        input logic [63:0] a, input logic [63:0] b);
      logic [1:0] pend;
      logic ok;
      int g;
      int t_acc;
      pend = pend_in;
      @(posedge clk); #1;
      bus.req_valid_i  = pend;
      bus.req_signed_i = sgn;
      bus.req_a_i      = a;
      bus.req_b_i      = b;
      while (pend != 2'b00) begin
         g = (pend == 2'b11) ? int'(!last_g) : int'(pend[1]);
         await_accept(2'b01 << g, ok, t_acc);
         if (!ok) begin
            bus.req_valid_i = 2'b00;
            return;
         end
         last_g = g[0];
         pend[g] = 1'b0;
         @(posedge clk); #1;
         bus.req_valid_i = pend;
         await_resp(g, prod(sgn[g], a[32*g +: 32], b[32*g +: 32]),
                    exp_lat(a[32*g +: 32], b[32*g +: 32]), t_acc);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_time_limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      logic ok;
      int t_acc;
      int w;
      int s0;
      logic saw;
      logic [63:0] ra;
      logic [63:0] rb;

      bus.req_valid_i  = 2'b00;
      bus.req_signed_i = 2'b00;
      bus.req_a_i      = 64'h0;
      bus.req_b_i      = 64'h0;
      bus.req_cancel_i = 2'b00;

      // Reset state.
      #20;
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_timeout", 64'(timeout), 64'h0);
      chk("rst_resp_valid", 64'(bus.resp_valid_o), 64'h0);
      chk("rst_result", bus.resp_result_o, 64'h0);
      chk("rst_start", 64'(bus.mul_start_o), 64'h0);
      chk("rst_operands", {bus.mul_ina_o, bus.mul_inb_o}, 64'h0);
      #7 rst = 1'b1;

      // Simultaneous signed pair: requester 0 first, then 1.
      serve(2'b11, 2'b11, {32'hFFFF_FFFF, 32'hFFFF_FFFE}, {32'hFFFF_FFFF, 32'h0000_0007});
      chk("pair_r1_result", last_result, 64'h1);
      // Next pair again starts with requester 0.
      serve(2'b11, 2'b10, {pick_op(), pick_op()}, {pick_op(), pick_op()});

      // Single unsigned request 3*5.
      serve(2'b01, 2'b00, {32'h0, 32'h3}, {32'h0, 32'h5});
      chk("single_result", bus.resp_result_o, 64'h0F);

      // Owner cancel ten cycles into BUSY: result dropped, output register untouched.
      @(posedge clk); #1;
      bus.req_valid_i  = 2'b01;
      bus.req_signed_i = 2'b00;
      bus.req_a_i      = {32'h0, 32'h0000_1111};
      bus.req_b_i      = {32'h0, 32'h0000_2222};
      await_accept((last_g == 1'b0) ? 2'b01 : 2'b01, ok, t_acc);
      last_g = 1'b0;
      @(posedge clk); #1;
      bus.req_valid_i = 2'b00;
      repeat (10) @(posedge clk);
      #1 bus.req_cancel_i = 2'b01;
      @(posedge clk); #1;
      bus.req_cancel_i = 2'b00;
      saw = 1'b0;
      for (int n = 0; n < 200 && busy; n++) begin
         @(negedge clk);
         if (bus.resp_valid_o != 2'b00) saw = 1'b1;
      end
      chk("cancel_no_resp", 64'(saw), 64'h0);
      chk("cancel_result_kept", bus.resp_result_o, last_result);
      chk("cancel_busy_drops", 64'(busy), 64'h0);
      serve(2'b01, 2'b01, {32'h0, 32'hFFFF_FFF0}, {32'h0, 32'h0000_0010});

      // Same-cycle cancel of the would-be winner: the other requester wins.
      w = int'(!last_g);
      @(posedge clk); #1;
      ra = {pick_op(), pick_op()};
      rb = {pick_op(), pick_op()};
      bus.req_valid_i  = 2'b11;
      bus.req_signed_i = 2'b01;
      bus.req_a_i      = ra;
      bus.req_b_i      = rb;
      bus.req_cancel_i = 2'b01 << w;
      await_accept(2'b01 << (1 - w), ok, t_acc);
      last_g = ~w[0];
      @(posedge clk); #1;
      bus.req_valid_i  = 2'b00;
      bus.req_cancel_i = 2'b00;
      if (ok) await_resp(1 - w, prod(bus.req_signed_i[1 - w], ra[32*(1-w) +: 32],
                         rb[32*(1-w) +: 32]), StdLat, t_acc);

      // Async reset mid-BUSY, released between edges.
      @(posedge clk); #1;
      bus.req_valid_i = 2'b10;
      bus.req_a_i     = {32'h0000_0123, 32'h0};
      bus.req_b_i     = {32'h0000_0456, 32'h0};
      await_accept(2'b10, ok, t_acc);
      @(posedge clk); #1;
      bus.req_valid_i = 2'b00;
      repeat (5) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_busy", 64'(busy), 64'h0);
      chk("arst_start", 64'(bus.mul_start_o), 64'h0);
      chk("arst_resp", {62'h0, bus.resp_valid_o}, 64'h0);
      chk("arst_result", bus.resp_result_o, 64'h0);
      chk("arst_accept", 64'(bus.req_accept_o), 64'h0);
      last_g = 1'b1;
      #3 rst = 1'b1;
      serve(2'b10, 2'b10, {32'hFFFF_FFFD, 32'h0}, {32'h0000_0009, 32'h0});
      chk("arst_fresh_result", last_result, 64'hFFFF_FFFF_FFFF_FFE5);

      // Watchdog with a multiplier that never becomes ready.
      never_ready = 1'b1;
      @(posedge clk); #1;
      bus.req_valid_i  = 2'b01;
      bus.req_signed_i = 2'b00;
      bus.req_a_i      = {32'h0, 32'h5};
      bus.req_b_i      = {32'h0, 32'h6};
      await_accept(2'b01, ok, t_acc);
      last_g = 1'b0;
      @(posedge clk); #1;
      bus.req_valid_i = 2'b00;
      while (cyc < t_acc + 64) @(negedge clk);
      chk("wd_before", 64'(timeout), 64'h0);
      @(negedge clk);
      chk("wd_set", 64'(timeout), 64'h1);
      repeat (30) @(negedge clk);
      chk("wd_sticky", 64'(timeout), 64'h1);
      chk("wd_still_busy", 64'(busy), 64'h1);
      @(posedge clk); #2 rst = 1'b0;
      never_ready = 1'b0;
      last_g = 1'b1;
      #3 rst = 1'b1;

      // Zero operand: bypassed when the feature is built in, a normal op otherwise.
      s0 = start_cycles;
      serve(2'b10, 2'b00, {32'h0, 32'h0}, {32'h0000_1234, 32'h0});
`ifdef MUL_ARBITER_ZERO_BYPASS_EN
      chk("bypass_no_start", 64'(start_cycles - s0), 64'h0);
`endif

      // Randomized traffic.
      for (int i = 0; i < 12; i++) begin
         serve(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)),
               {pick_op(), pick_op()}, {pick_op(), pick_op()});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
